// File: rtl/hdc_feature_frame_source.sv
// Per-channel sample collector feeding hdc_sensor_fusion with whole frames.
// Double-buffered fill/output banks with optional inter-frame pacing.
module hdc_feature_frame_source #(
  parameter int NUM_CHANNEL   = 214,
  parameter int CHANNEL_WIDTH = 2,
  parameter int PACE_CYCLES   = 0,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CHANNEL_WIDTH-1:0]              samp_data,
  input  logic                                  samp_valid,
  output logic                                  samp_ready,
  input  logic                                  samp_last,
  output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0]  features_top,
  output logic                                  fin_valid,
  input  logic                                  fin_ready,
  output logic [CNT_WIDTH-1:0]                  frames_sent,
  output logic                                  err_len
);

  localparam int FW = NUM_CHANNEL * CHANNEL_WIDTH;
  localparam int IW = NUM_CHANNEL > 1 ? $clog2(NUM_CHANNEL) : 1;
  localparam int PW = PACE_CYCLES > 1 ? $clog2(PACE_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_CH = IW'(NUM_CHANNEL - 1);
  localparam logic [PW-1:0] PACE_LOAD =
    PW'(PACE_CYCLES > 0 ? PACE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {F_FILL, F_WAIT, F_RESYNC} fill_t;
  typedef enum logic [1:0] {O_EMPTY, O_VALID, O_PACE} out_t;

  fill_t         fill_q, fill_d;
  out_t          out_q, out_d;
  logic [IW-1:0] ch_q, ch_d;
  logic [FW-1:0] buf_q, buf_d;
  logic [PW-1:0] pace_q, pace_d;
  logic          out_full_q, out_full_d;
  logic          acc, hs, out_free, swap, err_set;

  always_comb begin
    acc      = samp_valid && samp_ready;
    hs       = fin_valid && fin_ready;
    out_free = !out_full_q || hs;
    fill_d   = fill_q;
    ch_d     = ch_q;
    buf_d    = buf_q;
    swap     = 1'b0;
    err_set  = 1'b0;
    unique case (fill_q)
      F_FILL: begin
        if (acc) begin
          buf_d[int'(ch_q)*CHANNEL_WIDTH +: CHANNEL_WIDTH] = samp_data;
          if (ch_q == LAST_CH) begin
            ch_d = '0;
            if (!samp_last) begin
              err_set = 1'b1;
              fill_d  = F_RESYNC;
            end else if (out_free) begin
              swap = 1'b1;
            end else begin
              fill_d = F_WAIT;
            end
          end else if (samp_last) begin
            err_set = 1'b1;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      F_WAIT: begin
        if (out_free) begin
          swap   = 1'b1;
          fill_d = F_FILL;
        end
      end
      F_RESYNC: begin
        if (acc && samp_last) fill_d = F_FILL;
      end
      default: fill_d = F_FILL;
    endcase
  end

  // A swap in the handshake cycle wins over the release of the bank.
  always_comb begin
    out_d      = out_q;
    pace_d     = pace_q;
    out_full_d = out_full_q;
    if (hs)   out_full_d = 1'b0;
    if (swap) out_full_d = 1'b1;
    unique case (out_q)
      O_EMPTY: begin
        if (swap) out_d = O_VALID;
      end
      O_VALID: begin
        if (hs) begin
          if (PACE_CYCLES > 0) begin
            out_d  = O_PACE;
            pace_d = PACE_LOAD;
          end else if (!swap) begin
            out_d = O_EMPTY;
          end
        end
      end
      O_PACE: begin
        if (pace_q == '0) out_d = out_full_d ? O_VALID : O_EMPTY;
        else              pace_d = pace_q - 1'b1;
      end
      default: out_d = O_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q       <= F_FILL;
      out_q        <= O_EMPTY;
      ch_q         <= '0;
      buf_q        <= '0;
      pace_q       <= '0;
      out_full_q   <= 1'b0;
      samp_ready   <= 1'b0;
      fin_valid    <= 1'b0;
      features_top <= '0;
      frames_sent  <= '0;
      err_len      <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      out_q      <= out_d;
      ch_q       <= ch_d;
      buf_q      <= buf_d;
      pace_q     <= pace_d;
      out_full_q <= out_full_d;
      samp_ready <= fill_d != F_WAIT;
      fin_valid  <= out_d == O_VALID;
      if (swap) features_top <= buf_d;
      if (hs && frames_sent != '1) frames_sent <= frames_sent + 1'b1;
      if (err_set) err_len <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdc_feature_frame_source.sv
// Scoreboard bench for hdc_feature_frame_source (4 channels x 2 bits).
// Unpaced and 10-cycle paced instances share clock and reset.
module tb_hdc_feature_frame_source;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [1:0]  samp_data = '0;
  logic        samp_valid = 1'b0;
  logic        samp_ready;
  logic        samp_last = 1'b0;
  logic [7:0]  features_top;
  logic        fin_valid;
  logic        fin_ready = 1'b0;
  logic [15:0] frames_sent;
  logic        err_len;

  logic [1:0]  samp_data_p = '0;
  logic        samp_valid_p = 1'b0;
  logic        samp_ready_p;
  logic        samp_last_p = 1'b0;
  logic [7:0]  features_top_p;
  logic        fin_valid_p;
  logic        fin_ready_p = 1'b1;
  logic [15:0] frames_sent_p;
  logic        err_len_p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_p = -1;
  logic [7:0] exp_q[$];
  logic [7:0] exp_p[$];
  logic [7:0] exp_v;
  logic [7:0] exp_vp;

  hdc_feature_frame_source #(
    .NUM_CHANNEL(4), .CHANNEL_WIDTH(2), .PACE_CYCLES(0), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .samp_data(samp_data), .samp_valid(samp_valid),
    .samp_ready(samp_ready), .samp_last(samp_last),
    .features_top(features_top), .fin_valid(fin_valid),
    .fin_ready(fin_ready), .frames_sent(frames_sent),
    .err_len(err_len)
  );

  hdc_feature_frame_source #(
    .NUM_CHANNEL(4), .CHANNEL_WIDTH(2), .PACE_CYCLES(10), .CNT_WIDTH(16)
  ) dut_p (
    .clk(clk), .rst(rst),
    .samp_data(samp_data_p), .samp_valid(samp_valid_p),
    .samp_ready(samp_ready_p), .samp_last(samp_last_p),
    .features_top(features_top_p), .fin_valid(fin_valid_p),
    .fin_ready(fin_ready_p), .frames_sent(frames_sent_p),
    .err_len(err_len_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // A handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (fin_valid && fin_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got %h, expected no frame",
                 features_top);
      end else begin
        exp_v = exp_q.pop_front();
        if (features_top !== exp_v) begin
          errors++;
          $display("FAIL frame_data: got %h, expected %h",
                   features_top, exp_v);
        end
      end
    end
    if (fin_valid_p && fin_ready_p) begin
      checks++;
      if (exp_p.size() == 0) begin
        errors++;
        $display("FAIL pace_frame_unexpected: got %h, expected no frame",
                 features_top_p);
      end else begin
        exp_vp = exp_p.pop_front();
        if (features_top_p !== exp_vp) begin
          errors++;
          $display("FAIL pace_frame_data: got %h, expected %h",
                   features_top_p, exp_vp);
        end
      end
      if (last_hs_p >= 0) begin
        checks++;
        if (cyc - last_hs_p < 10) begin
          errors++;
          $display("FAIL pace_gap: got %0d cycles, expected >= 10",
                   cyc - last_hs_p);
        end
      end
      last_hs_p = cyc;
    end
  end

  task automatic send(input bit p, input logic [1:0] d, input logic l);
    int n = 0;
    if (p) begin
      samp_valid_p = 1'b1; samp_data_p = d; samp_last_p = l;
    end else begin
      samp_valid = 1'b1; samp_data = d; samp_last = l;
    end
    @(negedge clk);
    while (!(p ? samp_ready_p : samp_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL samp_accept: samp_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
    samp_valid = 1'b0; samp_last = 1'b0;
    samp_valid_p = 1'b0; samp_last_p = 1'b0;
  endtask

  task automatic send_frame(input bit p, input logic [7:0] f,
                            input bit push);
    if (push) begin
      if (p) exp_p.push_back(f);
      else   exp_q.push_back(f);
    end
    for (int i = 0; i < 4; i++) send(p, f[2*i +: 2], i == 3);
  endtask

  task automatic do_reset();
    samp_valid = 1'b0; samp_last = 1'b0;
    samp_valid_p = 1'b0; samp_last_p = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({samp_ready, fin_valid, features_top, frames_sent, err_len}
        !== '0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b v=%b f=%h n=%0d e=%b, expected all 0",
               samp_ready, fin_valid, features_top, frames_sent, err_len);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (samp_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_early: got %b, expected 0", samp_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (samp_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b, expected 1", samp_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    fin_ready = 1'b1;
    send_frame(0, 8'h39, 1);
    checks++;
    if (fin_valid !== 1'b1 || features_top !== 8'h39) begin
      errors++;
      $display("FAIL basic_latency: got v=%b f=%h, expected v=1 f=39",
               fin_valid, features_top);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (frames_sent !== 16'd1 || fin_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_count: got n=%0d v=%b, expected n=1 v=0",
               frames_sent, fin_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fin_ready = 1'b0;
    send_frame(0, 8'h1E, 1);
    send_frame(0, 8'hB4, 1);
    checks++;
    if (samp_ready !== 1'b0 || fin_valid !== 1'b1 ||
        features_top !== 8'h1E) begin
      errors++;
      $display("FAIL bp_hold: got rdy=%b v=%b f=%h, expected rdy=0 v=1 f=1e",
               samp_ready, fin_valid, features_top);
    end
    fork
      send_frame(0, 8'hC9, 1);
      begin
        repeat (6) @(posedge clk);
        #1;
        fin_ready = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (frames_sent !== 16'd3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got n=%0d pending=%0d, expected n=3 pending=0",
               frames_sent, exp_q.size());
    end
  endtask

  task automatic test_early_last();
    do_reset();
    fin_ready = 1'b1;
    send(0, 2'd1, 1'b0);
    send(0, 2'd2, 1'b1);
    send_frame(0, 8'hE4, 1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (err_len !== 1'b1 || frames_sent !== 16'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL early_last: got e=%b n=%0d pending=%0d, expected e=1 n=1 pending=0",
               err_len, frames_sent, exp_q.size());
    end
  endtask

  task automatic test_missing_last();
    do_reset();
    fin_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(0, 2'd3, 1'b0);
    send(0, 2'd2, 1'b0);
    send(0, 2'd1, 1'b1);
    checks++;
    if (err_len !== 1'b1 || fin_valid !== 1'b0) begin
      errors++;
      $display("FAIL resync_state: got e=%b v=%b, expected e=1 v=0",
               err_len, fin_valid);
    end
    send_frame(0, 8'h1B, 1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (frames_sent !== 16'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL resync_frames: got n=%0d pending=%0d, expected n=1 pending=0",
               frames_sent, exp_q.size());
    end
  endtask

  task automatic test_pacing();
    do_reset();
    last_hs_p = -1;
    fin_ready_p = 1'b1;
    send_frame(1, 8'h39, 1);
    checks++;
    if (fin_valid_p !== 1'b1 || features_top_p !== 8'h39) begin
      errors++;
      $display("FAIL pace_first: got v=%b f=%h, expected v=1 f=39",
               fin_valid_p, features_top_p);
    end
    send_frame(1, 8'hA5, 1);
    send_frame(1, 8'h5A, 1);
    send_frame(1, 8'hF0, 1);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (frames_sent_p !== 16'd4 || exp_p.size() != 0) begin
      errors++;
      $display("FAIL pace_count: got n=%0d pending=%0d, expected n=4 pending=0",
               frames_sent_p, exp_p.size());
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    fin_ready = 1'b1;
    send_frame(0, 8'h93, 1);
    repeat (3) @(posedge clk);
    #1;
    fin_ready = 1'b0;
    send_frame(0, 8'hAA, 0);
    send(0, 2'd3, 1'b0);
    send(0, 2'd3, 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (fin_valid !== 1'b0 || frames_sent !== 16'd0 ||
        features_top !== 8'h00 || samp_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b n=%0d f=%h rdy=%b, expected 0 0 00 0",
               fin_valid, frames_sent, features_top, samp_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    fin_ready = 1'b1;
    @(posedge clk);
    #1;
    send_frame(0, 8'h6C, 1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (frames_sent !== 16'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_frame: got n=%0d pending=%0d, expected n=1 pending=0",
               frames_sent, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_pacing();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
